// File: rtl/gcd_ctrl.sv
// gcd_ctrl: control FSM for the subtract-and-compare GCD datapath.
// Ports: clk/rst_n, start, x_eq_y/x_gt_y in; dp selects/loads, ready/busy/done/err/iter_cnt out.
module gcd_ctrl #(
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             x_eq_y,
  input  logic             x_gt_y,
  output logic             xsel,
  output logic             xload,
  output logic             ysel,
  output logic             yload,
  output logic             sub_sel,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_Y,
    S_COMPUTE,
    S_FINISH
  } state_t;

  state_t state;
  logic   at_max;

  assign at_max = (iter_cnt == CNT_W'(MAX_ITER));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      err      <= 1'b0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_Y;
            iter_cnt <= '0;
            err      <= 1'b0;
            ready    <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_LOAD_Y: begin
          state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          if (x_eq_y) begin
            state <= S_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (at_max) begin
            state <= S_FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            iter_cnt <= iter_cnt + 1'b1;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Loads are Mealy and gated by rst_n so a held start
  // cannot load dp while reset is asserted.
  always_comb begin
    xsel    = 1'b0;
    xload   = 1'b0;
    ysel    = 1'b0;
    yload   = 1'b0;
    sub_sel = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            xsel  = 1'b1;
            xload = 1'b1;
          end
        end
        S_LOAD_Y: begin
          ysel  = 1'b1;
          yload = 1'b1;
        end
        S_COMPUTE: begin
          if (!x_eq_y && !at_max) begin
            if (x_gt_y) begin
              xload = 1'b1;
            end else begin
              sub_sel = 1'b1;
              yload   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: randomized self-checking bench for gcd_ctrl with a dp model.
// Drives operands on din, checks latency, counts, err and result.
module tb_gcd_ctrl;
  localparam int MAX_ITER = 255;
  localparam int CNT_W    = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             x_eq_y;
  logic             x_gt_y;
  logic             xsel;
  logic             xload;
  logic             ysel;
  logic             yload;
  logic             sub_sel;
  logic             ready;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] iter_cnt;
  logic [7:0]       din;
  logic [7:0]       xr;
  logic [7:0]       yr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gcd_ctrl #(.MAX_ITER(MAX_ITER), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .x_eq_y(x_eq_y), .x_gt_y(x_gt_y),
    .xsel(xsel), .xload(xload), .ysel(ysel), .yload(yload),
    .sub_sel(sub_sel), .ready(ready), .busy(busy), .done(done),
    .err(err), .iter_cnt(iter_cnt)
  );

  // datapath model
  always_ff @(posedge clk) begin
    if (xload) xr <= xsel ? din : (sub_sel ? yr - xr : xr - yr);
    if (yload) yr <= ysel ? din : (sub_sel ? yr - xr : xr - yr);
  end
  assign x_eq_y = (xr == yr);
  assign x_gt_y = (xr >= yr);

  function automatic int euclid(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic ref_gcd(input int a, input int b, output int n,
                         output int xs, output int ys, output int e,
                         output int g);
    int x = a;
    int y = b;
    n = 0; xs = 0; ys = 0;
    while (x != y && n < MAX_ITER) begin
      if (x > y) begin x = x - y; xs++; end
      else begin y = y - x; ys++; end
      n++;
    end
    e = (x != y) ? 1 : 0;
    g = euclid(a, b);
  endtask

  task automatic run_gcd(input int a, input int b, input bit hold,
                         input bit noise, input string name);
    int n, xs, ys, e, g;
    int cyc = 0;
    int xl = 0;
    int yl = 0;
    bit bad = 0;
    bit got = 0;
    ref_gcd(a, b, n, xs, ys, e, g);
    @(negedge clk); start = 1'b1; din = 8'(a); #1;
    tests++;
    if (!(ready === 1 && xload === 1 && xsel === 1 && yload === 0)) begin
      fails++;
      $display("FAIL %s accept: ready=%b xload=%b xsel=%b yload=%b want 1 1 1 0",
               name, ready, xload, xsel, yload);
    end
    @(posedge clk); #1;
    tests++;
    if (err !== 1'b0 || iter_cnt !== '0) begin
      fails++;
      $display("FAIL %s clear: err=%b iter=%0d want 0 0", name, err, iter_cnt);
    end
    @(negedge clk); din = 8'(b); start = hold; #1;
    tests++;
    if (!(busy === 1 && ready === 0 && yload === 1 && ysel === 1 && xload === 0)) begin
      fails++;
      $display("FAIL %s load_y: busy=%b ready=%b yload=%b ysel=%b xload=%b",
               name, busy, ready, yload, ysel, xload);
    end
    for (cyc = 2; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (noise) start = 1'($urandom_range(0, 1));
      din = 8'($urandom);
      #1;
      if (done === 1'b1) begin got = 1; break; end
      if (busy !== 1'b1 || ready !== 1'b0) bad = 1;
      if (xload === 1'b1) begin
        xl++;
        if (sub_sel !== 1'b0 || xsel !== 1'b0 || yload !== 1'b0) bad = 1;
      end
      if (yload === 1'b1) begin
        yl++;
        if (sub_sel !== 1'b1 || ysel !== 1'b0) bad = 1;
      end
    end
    tests++;
    if (!got || cyc != n + 3) begin
      fails++;
      $display("FAIL %s latency: done at %0d (seen=%0d) want %0d", name, cyc, got, n + 3);
    end
    tests++;
    if (iter_cnt !== CNT_W'(n) || err !== e[0]) begin
      fails++;
      $display("FAIL %s count: iter=%0d err=%b want %0d %0d", name, iter_cnt, err, n, e);
    end
    tests++;
    if (xl != xs || yl != ys || bad) begin
      fails++;
      $display("FAIL %s steps: xl=%0d yl=%0d bad=%0d want %0d %0d 0", name, xl, yl, bad, xs, ys);
    end
    tests++;
    if (busy !== 1'b0 || xload !== 1'b0 || yload !== 1'b0) begin
      fails++;
      $display("FAIL %s finish: busy=%b xload=%b yload=%b want 0", name, busy, xload, yload);
    end
    if (e == 0) begin
      tests++;
      if (xr !== 8'(g) || yr !== 8'(g)) begin
        fails++;
        $display("FAIL %s result: x=%0d y=%0d want %0d", name, xr, yr, g);
      end
    end
    if (!hold) begin
      @(negedge clk); start = 1'b0; #1;
      tests++;
      if (done !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || iter_cnt !== CNT_W'(n)) begin
        fails++;
        $display("FAIL %s idle: done=%b ready=%b busy=%b iter=%0d", name, done, ready, busy, iter_cnt);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    tests++;
    if (!(ready === 1 && busy === 0 && done === 0 && err === 0 &&
          iter_cnt === '0 && xload === 0 && yload === 0 &&
          xsel === 0 && ysel === 0 && sub_sel === 0)) begin
      fails++;
      $display("FAIL %s: rdy=%b bsy=%b dn=%b err=%b it=%0d xl=%b yl=%b xs=%b ys=%b ss=%b",
               name, ready, busy, done, err, iter_cnt, xload, yload, xsel, ysel, sub_sel);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); start = 1'b1; din = 8'd5; #2;
    rst_n = 1'b0; #1;
    check_reset_vals("reset_async");
    @(negedge clk); start = 1'b0; rst_n = 1'b1; #1;
    check_reset_vals("reset_release");
  endtask

  task automatic test_directed();
    run_gcd(48, 18, 0, 0, "gcd48_18");
    run_gcd(7, 7, 0, 0, "gcd7_7");
    run_gcd(0, 5, 0, 0, "gcd0_5");
    run_gcd(9, 6, 0, 0, "gcd9_6");
    run_gcd(1, 255, 0, 0, "gcd1_255");
    run_gcd(0, 0, 0, 0, "gcd0_0");
  endtask

  task automatic test_random();
    int a, b;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      b = int'($urandom_range(1, 255));
      if (i % 2 == 1) begin int t = a; a = b; b = t; end
      run_gcd(a, b, 0, 0, "random");
    end
  endtask

  task automatic test_ignore_start();
    run_gcd(240, 36, 0, 1, "noise240_36");
    run_gcd(int'($urandom_range(1, 255)), int'($urandom_range(1, 255)), 0, 1, "noise_rand");
  endtask

  task automatic test_back_to_back();
    run_gcd(12, 8, 1, 0, "b2b_12_8");
    run_gcd(35, 21, 1, 0, "b2b_35_21");
    run_gcd(100, 75, 0, 0, "b2b_100_75");
  endtask

  task automatic test_midrun_reset();
    @(negedge clk); start = 1'b1; din = 8'd48;
    @(negedge clk); start = 1'b0; din = 8'd18;
    repeat (3) @(negedge clk);
    start = 1'b1; #2;
    rst_n = 1'b0; #1;
    check_reset_vals("midrun_reset");
    @(negedge clk); start = 1'b0; rst_n = 1'b1;
    run_gcd(48, 18, 0, 0, "after_reset");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    din   = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gcd_ctrl.md
Name: gcd_ctrl

Overview:
Mealy-style control FSM that sequences the 8-bit subtract-and-compare GCD datapath (dp). It loads operand X and then operand Y from the shared din bus over two cycles. It then steers the subtractor and register loads from the dp comparator flags until x == y. Completion is reported with a done pulse, an iteration count and a timeout error flag, because a zero operand never converges. It sits between the top-level button/switch logic and dp, and drives every dp control input.

Parameters:
MAX_ITER, 255, maximum subtraction iterations before abort; range 1 to 2^CNT_W-1
CNT_W, 8, width of the iteration counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin operation; sampled only in IDLE; din must hold X in this cycle
x_eq_y  input  1  dp comparator, x == y
x_gt_y  input  1  dp comparator, x >= y (dp implements >=; equality has priority here)
xsel  output  1  1 = x loads din, 0 = x loads diff
xload  output  1  x register load enable
ysel  output  1  1 = y loads din, 0 = y loads diff
yload  output  1  y register load enable
sub_sel  output  1  0 = diff is x-y, 1 = diff is y-x
ready  output  1  high in IDLE
busy  output  1  high in LOAD_Y and COMPUTE
done  output  1  one-cycle pulse in FINISH
err  output  1  timeout flag; set on abort, cleared on next accepted start
iter_cnt  output  CNT_W  subtractions performed in current/last run

Behaviour:
- Architecture: state register, iter_cnt and err are flops with async clear on rst_n low. Outputs xsel/xload/ysel/yload/sub_sel are combinational from state and inputs (Mealy).
- Reset values: state = IDLE, iter_cnt = 0, err = 0, done = 0, busy = 0, ready = 1, all load/sel outputs = 0. While rst_n is low, all loads are forced to 0 regardless of start.
- Default outputs: all load/sel = 0 unless listed below.
- IDLE:
  - If start = 1: xsel = 1, xload = 1 (X captured from din this edge); iter_cnt <= 0; err <= 0; next state LOAD_Y.
  - Otherwise remain in IDLE; iter_cnt and err hold the last result.
- LOAD_Y: ysel = 1, yload = 1 (din must hold Y this cycle); next state COMPUTE. start is ignored.
- COMPUTE (dp flags are valid, registers settled), priority order:
  1. x_eq_y = 1: no load; next state FINISH.
  2. iter_cnt == MAX_ITER: no load; err <= 1; next state FINISH.
  3. x_gt_y = 1: sub_sel = 0, xsel = 0, xload = 1 (x <= x - y); iter_cnt++.
  4. Else: sub_sel = 1, ysel = 0, yload = 1 (y <= y - x); iter_cnt++.
- FINISH: done = 1 for exactly one cycle; x and y are not modified; next state IDLE. The result is read from dp gcd_rslt, which stays stable until the next start.
- Latency: done asserts at cycle N+3 after the start cycle, where N = iter_cnt (start cycle = 0). A timeout run has N = MAX_ITER.
- iter_cnt never wraps; the MAX_ITER check precedes any increment.
- start during LOAD_Y, COMPUTE or FINISH is ignored; no queueing. start held high across FINISH→IDLE is accepted in IDLE as a new run.
- Zero operand: x = 0, y = 0 gives equality immediately (result 0, err = 0). A single zero operand never converges and must end via timeout with err = 1.
- Async reset mid-run: immediate return to IDLE with loads deasserted; dp register contents are don't-care afterwards.
- Illegal state encodings recover to IDLE on the next clock.

Test Plan:
- Reset: assert rst_n low mid-cycle with start = 1 → ready = 1, busy = 0, done = 0, err = 0, iter_cnt = 0, all loads 0 asynchronously.
- GCD(48,18): start with din = 48 at cycle 0, din = 18 at cycle 1 → subtraction sequence x 30, x 12, y 6, x 6; done at cycle 7; iter_cnt = 4; gcd_rslt = 6; err = 0.
- GCD(7,7) → no subtractions; done at cycle 3; iter_cnt = 0; gcd_rslt = 7.
- GCD(0,5), MAX_ITER = 255 → 255 y-loads with sub_sel = 1; done at cycle 258; err = 1; iter_cnt = 255. Next start of GCD(9,6) → err clears at acceptance; result 3, iter_cnt = 2, done at cycle 5.
- GCD(1,255) → 254 y subtractions; done at cycle 257; err = 0; gcd_rslt = 1 (boundary just under timeout).
- start pulses during COMPUTE are ignored; rst_n pulse mid-COMPUTE returns to IDLE; a fresh start then completes normally.
